// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - windowed, mirrored 6502 bus memory bank with req/ack handshake
module mem_bank #(
  parameter int               WIDTH          = 8,
  parameter int               ADDR_WIDTH     = 16,
  parameter int               DEPTH          = 2048,
  parameter int               BASE           = 0,
  parameter int               SPAN           = 8192,
  parameter int               READ_LATENCY   = 1,
  parameter bit               READ_ONLY      = 1'b0,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  hit,
  output logic                  ack,
  output logic                  busy,
  output logic                  wr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] BASE_W = (ADDR_WIDTH+1)'(BASE);
  localparam logic [ADDR_WIDTH:0] SPAN_W = (ADDR_WIDTH+1)'(SPAN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_bank: DEPTH must be a power of 2");
  end
  if (SPAN < DEPTH || (SPAN % DEPTH) != 0) begin : g_bad_span
    $error("mem_bank: SPAN must be an integer multiple of DEPTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("mem_bank: READ_LATENCY must be 1..4");
  end

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [1:0]        wait_q, wait_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              ack_q, ack_d;
  logic              wr_err_q, wr_err_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [WIDTH-1:0]  mem_wdata;
  logic [ADDR_WIDTH:0] offset;
  logic [IDX_W-1:0]  index;
  logic              accept;

  logic [WIDTH-1:0]  mem [DEPTH];

  // An address below BASE wraps the one-bit-wider offset above SPAN, so a
  // single compare covers both window edges.
  assign offset = {1'b0, addr} - BASE_W;
  assign hit    = (offset < SPAN_W);
  assign index  = offset[IDX_W-1:0];
  assign busy   = (state_q != ST_IDLE);
  assign accept = req && hit && !busy;
  assign dout   = dout_q;
  assign ack    = ack_q;
  assign wr_err = wr_err_q;

  // State, clear counter, read pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q <= '0;
      wait_q    <= '0;
      hold_q    <= '0;
      dout_q    <= '0;
      ack_q     <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Next-state decode, storage write port selection and response generation
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    dout_d    = dout_q;
    ack_d     = 1'b0;
    wr_err_d  = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = index;
    mem_wdata = din;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = CLEAR_VALUE;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (we) begin
            ack_d = 1'b1;
            if (READ_ONLY) begin
              wr_err_d = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end else if (READ_LATENCY == 1) begin
            dout_d = mem[index];
            ack_d  = 1'b1;
          end else begin
            hold_d  = mem[index];
            wait_d  = WAIT_INIT;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (wait_q == 2'd0) begin
          dout_d  = hold_q;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Storage write port; reset itself never touches the contents
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - directed self-checking bench for mem_bank
module tb_mem_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v  [4];
  logic        req_v    [4];
  logic        we_v     [4];
  logic [15:0] addr_v   [4];
  logic [7:0]  din_v    [4];
  logic [7:0]  dout_v   [4];
  logic        hit_v    [4];
  logic        ack_v    [4];
  logic        busy_v   [4];
  logic        wr_err_v [4];

  int total = 0;
  int bad   = 0;

  mem_bank #(.DEPTH(16), .SPAN(64), .BASE(0), .READ_LATENCY(3),
             .READ_ONLY(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)) u_a (
    .clk(clk), .reset(reset_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .din(din_v[0]), .dout(dout_v[0]), .hit(hit_v[0]), .ack(ack_v[0]),
    .busy(busy_v[0]), .wr_err(wr_err_v[0]));

  mem_bank #(.DEPTH(2048), .SPAN(8192), .BASE(0), .READ_LATENCY(1),
             .READ_ONLY(1'b0), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'h00)) u_b (
    .clk(clk), .reset(reset_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .din(din_v[1]), .dout(dout_v[1]), .hit(hit_v[1]), .ack(ack_v[1]),
    .busy(busy_v[1]), .wr_err(wr_err_v[1]));

  mem_bank #(.DEPTH(32), .SPAN(32), .BASE(0), .READ_LATENCY(2),
             .READ_ONLY(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hC3)) u_c (
    .clk(clk), .reset(reset_v[2]), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
    .din(din_v[2]), .dout(dout_v[2]), .hit(hit_v[2]), .ack(ack_v[2]),
    .busy(busy_v[2]), .wr_err(wr_err_v[2]));

  mem_bank #(.DEPTH(16), .SPAN(32), .BASE(16'h4000), .READ_LATENCY(4),
             .READ_ONLY(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)) u_d (
    .clk(clk), .reset(reset_v[3]), .req(req_v[3]), .we(we_v[3]), .addr(addr_v[3]),
    .din(din_v[3]), .dout(dout_v[3]), .hit(hit_v[3]), .ack(ack_v[3]),
    .busy(busy_v[3]), .wr_err(wr_err_v[3]));

  task automatic bus_write(input int id, input logic [15:0] a, input logic [7:0] d);
    addr_v[id] = a;
    din_v[id]  = d;
    we_v[id]   = 1'b1;
    req_v[id]  = 1'b1;
    @(negedge clk);
    req_v[id]  = 1'b0;
    we_v[id]   = 1'b0;
  endtask

  task automatic bus_read(input int id, input logic [15:0] a, output logic [7:0] d, output int lat);
    addr_v[id] = a;
    we_v[id]   = 1'b0;
    req_v[id]  = 1'b1;
    lat = -1;
    d   = 8'hxx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_v[id] = 1'b0;
      if (ack_v[id] === 1'b1) begin
        lat = c;
        d   = dout_v[id];
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_busy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dout_v[i] !== 8'h00 || ack_v[i] !== 1'b0 || wr_err_v[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: dout=%h ack=%b wr_err=%b, want 00 0 0",
                 i, dout_v[i], ack_v[i], wr_err_v[i]);
      end
      total++;
      if (busy_v[i] !== exp_busy[i]) begin
        bad++;
        $display("FAIL reset_busy[%0d]: got %b want %b", i, busy_v[i], exp_busy[i]);
      end
    end
    for (int i = 0; i < 4; i++) reset_v[i] = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    bit ack_seen = 1'b0;
    logic [7:0] d;
    int lat;
    addr_v[0] = 16'h0000;
    we_v[0]   = 1'b0;
    req_v[0]  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (busy_v[0] === 1'b1) busy_cnt++;
      if (ack_v[0] !== 1'b0) ack_seen = 1'b1;
      @(negedge clk);
    end
    req_v[0] = 1'b0;
    total++;
    if (busy_cnt != 16) begin
      bad++;
      $display("FAIL clear_busy_cycles: got %0d want 16", busy_cnt);
    end
    total++;
    if (busy_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_busy: got %b want 0", busy_v[0]);
    end
    total++;
    if (ack_seen) begin
      bad++;
      $display("FAIL clear_req_ignored: got ack during clear, want none");
    end
    total++;
    if (busy_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL noclear_busy: got %b want 0", busy_v[1]);
    end
    repeat (20) @(negedge clk);
    total++;
    if (busy_v[2] !== 1'b0 || busy_v[3] !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_others: busy_c=%b busy_d=%b want 0 0", busy_v[2], busy_v[3]);
    end
    for (int i = 0; i < 16; i++) begin
      bus_read(0, 16'(i), d, lat);
      total++;
      if (d !== 8'h00 || lat != 3) begin
        bad++;
        $display("FAIL clear_readback[%0d]: data=%h lat=%0d want 00 3", i, d, lat);
      end
    end
  endtask

  task automatic test_latency();
    bus_write(0, 16'h0003, 8'h5A);
    total++;
    if (ack_v[0] !== 1'b1 || wr_err_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL lat_write_ack: ack=%b wr_err=%b want 1 0", ack_v[0], wr_err_v[0]);
    end
    addr_v[0] = 16'h0003;
    we_v[0]   = 1'b0;
    req_v[0]  = 1'b1;
    @(negedge clk);
    req_v[0]  = 1'b0;
    total++;
    if (busy_v[0] !== 1'b1 || ack_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL lat_cycle1: busy=%b ack=%b want 1 0", busy_v[0], ack_v[0]);
    end
    @(negedge clk);
    total++;
    if (busy_v[0] !== 1'b1 || ack_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL lat_cycle2: busy=%b ack=%b want 1 0", busy_v[0], ack_v[0]);
    end
    @(negedge clk);
    total++;
    if (busy_v[0] !== 1'b0 || ack_v[0] !== 1'b1 || dout_v[0] !== 8'h5A) begin
      bad++;
      $display("FAIL lat_cycle3: busy=%b ack=%b dout=%h want 0 1 5a", busy_v[0], ack_v[0], dout_v[0]);
    end
    bus_write(0, 16'h0005, 8'h11);
    total++;
    if (ack_v[0] !== 1'b1 || dout_v[0] !== 8'h5A) begin
      bad++;
      $display("FAIL dout_hold_write: ack=%b dout=%h want 1 5a", ack_v[0], dout_v[0]);
    end
    @(negedge clk);
    total++;
    if (ack_v[0] !== 1'b0 || dout_v[0] !== 8'h5A) begin
      bad++;
      $display("FAIL ack_pulse: ack=%b dout=%h want 0 5a", ack_v[0], dout_v[0]);
    end
  endtask

  task automatic test_mirror();
    logic [15:0] mir [3] = '{16'h0005, 16'h1005, 16'h1805};
    logic [7:0] d;
    int lat;
    bus_write(1, 16'h0805, 8'h77);
    total++;
    if (ack_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL mirror_write_ack: got %b want 1", ack_v[1]);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(1, mir[i], d, lat);
      total++;
      if (d !== 8'h77 || lat != 1) begin
        bad++;
        $display("FAIL mirror_read[%h]: data=%h lat=%0d want 77 1", mir[i], d, lat);
      end
    end
    addr_v[1] = 16'h1FFF;
    #1;
    total++;
    if (hit_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL hit_top_edge: got %b want 1", hit_v[1]);
    end
    addr_v[1] = 16'h2005;
    we_v[1]   = 1'b0;
    req_v[1]  = 1'b1;
    #1;
    total++;
    if (hit_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL miss_hit: got %b want 0", hit_v[1]);
    end
    @(negedge clk);
    req_v[1] = 1'b0;
    total++;
    if (ack_v[1] !== 1'b0) begin
      bad++;
      $display("FAIL miss_no_ack: got %b want 0", ack_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    we_v[1]  = 1'b1;
    req_v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_v[1] = 16'h0100 + 16'(k);
      din_v[1]  = 8'(k + 1);
      @(negedge clk);
      total++;
      if (ack_v[1] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_write_ack[%0d]: got %b want 1", k, ack_v[1]);
      end
    end
    we_v[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr_v[1] = 16'h0100 + 16'(k);
      @(negedge clk);
      total++;
      if (ack_v[1] !== 1'b1 || dout_v[1] !== 8'(k + 1)) begin
        bad++;
        $display("FAIL b2b_read[%0d]: ack=%b dout=%h want 1 %h", k, ack_v[1], dout_v[1], 8'(k + 1));
      end
    end
    req_v[1] = 1'b0;
    @(negedge clk);
    total++;
    if (ack_v[1] !== 1'b0 || dout_v[1] !== 8'h03) begin
      bad++;
      $display("FAIL b2b_end: ack=%b dout=%h want 0 03", ack_v[1], dout_v[1]);
    end
  endtask

  task automatic test_read_only();
    logic [7:0] d;
    int lat;
    bus_write(2, 16'h0010, 8'h00);
    total++;
    if (ack_v[2] !== 1'b1 || wr_err_v[2] !== 1'b1) begin
      bad++;
      $display("FAIL rom_write: ack=%b wr_err=%b want 1 1", ack_v[2], wr_err_v[2]);
    end
    @(negedge clk);
    total++;
    if (ack_v[2] !== 1'b0 || wr_err_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL rom_pulse: ack=%b wr_err=%b want 0 0", ack_v[2], wr_err_v[2]);
    end
    bus_read(2, 16'h0010, d, lat);
    total++;
    if (d !== 8'hC3 || lat != 2) begin
      bad++;
      $display("FAIL rom_reread: data=%h lat=%0d want c3 2", d, lat);
    end
    bus_write(2, 16'h0020, 8'h00);
    total++;
    if (hit_v[2] !== 1'b0 || ack_v[2] !== 1'b0 || wr_err_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL rom_miss: hit=%b ack=%b wr_err=%b want 0 0 0", hit_v[2], ack_v[2], wr_err_v[2]);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] ha [4] = '{16'h3FFF, 16'h4000, 16'h401F, 16'h4020};
    logic        hx [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] d;
    int lat;
    int busy_cnt = 0;
    bit ack_seen = 1'b0;
    bus_write(3, 16'h4003, 8'hAB);
    bus_read(3, 16'h4003, d, lat);
    total++;
    if (d !== 8'hAB || lat != 4) begin
      bad++;
      $display("FAIL lat4_read: data=%h lat=%0d want ab 4", d, lat);
    end
    for (int i = 0; i < 4; i++) begin
      addr_v[3] = ha[i];
      #1;
      total++;
      if (hit_v[3] !== hx[i]) begin
        bad++;
        $display("FAIL hit_edge[%h]: got %b want %b", ha[i], hit_v[3], hx[i]);
      end
    end
    @(negedge clk);
    addr_v[3] = 16'h4003;
    we_v[3]   = 1'b0;
    req_v[3]  = 1'b1;
    @(negedge clk);
    req_v[3]   = 1'b0;
    total++;
    if (busy_v[3] !== 1'b1) begin
      bad++;
      $display("FAIL abort_accepted: busy=%b want 1", busy_v[3]);
    end
    reset_v[3] = 1'b1;
    @(negedge clk);
    reset_v[3] = 1'b0;
    total++;
    if (dout_v[3] !== 8'h00 || busy_v[3] !== 1'b1 || ack_v[3] !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset_state: dout=%h busy=%b ack=%b want 00 1 0", dout_v[3], busy_v[3], ack_v[3]);
    end
    for (int i = 0; i < 20; i++) begin
      if (busy_v[3] === 1'b1) busy_cnt++;
      if (ack_v[3] !== 1'b0) ack_seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (ack_seen) begin
      bad++;
      $display("FAIL abort_no_ack: got ack after reset, want none");
    end
    total++;
    if (busy_cnt != 16) begin
      bad++;
      $display("FAIL abort_clear_cycles: got %0d want 16", busy_cnt);
    end
    bus_read(3, 16'h4003, d, lat);
    total++;
    if (d !== 8'h00 || lat != 4) begin
      bad++;
      $display("FAIL abort_cleared_word: data=%h lat=%0d want 00 4", d, lat);
    end
    bus_read(3, 16'h4013, d, lat);
    total++;
    if (d !== 8'h00 || lat != 4) begin
      bad++;
      $display("FAIL abort_cleared_mirror: data=%h lat=%0d want 00 4", d, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      reset_v[i] = 1'b1;
      req_v[i]   = 1'b0;
      we_v[i]    = 1'b0;
      addr_v[i]  = 16'h0000;
      din_v[i]   = 8'h00;
    end
    test_reset();
    test_clear();
    test_latency();
    test_mirror();
    test_back_to_back();
    test_read_only();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
